// File: rtl/key_onehot_capture.sv
// Synchronises and debounces a raw push-button vector, then reports one new
// single-key press per press/release cycle as a registered one-hot vector.
module key_onehot_capture #(
   parameter int N_KEYS = 15,
   parameter int DB_CNT = 1000000,
   parameter int CNT_W  = 20
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [N_KEYS-1:0] key_in,
   output logic [N_KEYS-1:0] key_onehot,
   output logic              key_valid,
   output logic              multi_err,
   output logic              key_busy
);

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CNT - 1);

   typedef enum logic {
      IDLE = 1'b0,
      HOLD = 1'b1
   } state_t;

   logic [N_KEYS-1:0] sync_vec;
   logic [N_KEYS-1:0] cand_reg;
   logic [N_KEYS-1:0] stable_reg, stable_next;
   logic [CNT_W-1:0]  cnt_reg, cnt_next;

   state_t            state_reg, state_next;
   logic [N_KEYS-1:0] onehot_reg, onehot_next;
   logic              valid_reg, valid_next;
   logic              err_reg, err_next;

   logic              any_key;
   logic              multi_key;

   // Two-flop synchroniser per key; raw levels never reach logic directly.
   genvar gi;
   generate
      for (gi = 0; gi < N_KEYS; gi++) begin : g_sync
         logic meta_reg;
         logic sync_reg;

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               meta_reg <= 1'b0;
               sync_reg <= 1'b0;
            end else begin
               meta_reg <= key_in[gi];
               sync_reg <= meta_reg;
            end
         end

         assign sync_vec[gi] = sync_reg;
      end
   endgenerate

   // Whole-vector debounce: any difference restarts the stability count.
   always_comb begin
      cnt_next    = cnt_reg;
      stable_next = stable_reg;
      if (sync_vec != cand_reg) begin
         cnt_next = '0;
      end else if (cnt_reg == CNT_MAX) begin
         stable_next = cand_reg;
      end else begin
         cnt_next = cnt_reg + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cand_reg   <= '0;
         stable_reg <= '0;
         cnt_reg    <= '0;
      end else begin
         cand_reg   <= sync_vec;
         stable_reg <= stable_next;
         cnt_reg    <= cnt_next;
      end
   end

   // Clearing the lowest set bit leaves something only if two or more keys are down.
   assign any_key   = |stable_reg;
   assign multi_key = |(stable_reg & (stable_reg - N_KEYS'(1)));

   always_comb begin
      state_next  = state_reg;
      onehot_next = onehot_reg;
      valid_next  = 1'b0;
      err_next    = 1'b0;
      case (state_reg)
         IDLE: begin
            if (any_key) begin
               state_next = HOLD;
               if (multi_key) begin
                  err_next = 1'b1;
               end else begin
                  valid_next  = 1'b1;
                  onehot_next = stable_reg;
               end
            end
         end
         HOLD: begin
            if (!any_key) begin
               state_next = IDLE;
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg  <= IDLE;
         onehot_reg <= '0;
         valid_reg  <= 1'b0;
         err_reg    <= 1'b0;
      end else begin
         state_reg  <= state_next;
         onehot_reg <= onehot_next;
         valid_reg  <= valid_next;
         err_reg    <= err_next;
      end
   end

   assign key_onehot = onehot_reg;
   assign key_valid  = valid_reg;
   assign multi_err  = err_reg;
   assign key_busy   = (state_reg == HOLD);

endmodule

// File: tb/tb_key_onehot_capture.sv
// Bench for key_onehot_capture: table vectors, hand-written latency/reset
// sequences and random key activity checked cycle by cycle against a model.
module tb_key_onehot_capture;

   localparam int N_KEYS = 15;
   localparam int DB_CNT = 4;
   localparam int CNT_W  = 3;
   localparam int DEPTH  = 65536;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic [N_KEYS-1:0] key_in = '0;
   logic [N_KEYS-1:0] key_onehot;
   logic              key_valid;
   logic              multi_err;
   logic              key_busy;

   key_onehot_capture #(
      .N_KEYS(N_KEYS),
      .DB_CNT(DB_CNT),
      .CNT_W (CNT_W)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .key_in    (key_in),
      .key_onehot(key_onehot),
      .key_valid (key_valid),
      .multi_err (multi_err),
      .key_busy  (key_busy)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int fails  = 0;
   int n_valid = 0;
   int n_err   = 0;

   // Reference model: history of sampled key vectors since reset release.
   logic [N_KEYS-1:0] hist [DEPTH];
   int                cyc = 0;
   logic [N_KEYS-1:0] m_stable = '0;
   logic [N_KEYS-1:0] m_onehot = '0;
   logic              m_valid = 1'b0;
   logic              m_err = 1'b0;
   logic              m_hold = 1'b0;

   typedef struct {
      logic [N_KEYS-1:0] pattern;
      int                hold;
      int                exp_valid;
      int                exp_err;
      logic [N_KEYS-1:0] exp_onehot;
   } vec_t;

   vec_t vecs [8];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [N_KEYS-1:0] samp(input int k);
      if (k < 0) return '0;
      return hist[k];
   endfunction

   task automatic model_reset();
      cyc      = 0;
      m_stable = '0;
      m_onehot = '0;
      m_valid  = 1'b0;
      m_err    = 1'b0;
      m_hold   = 1'b0;
   endtask

   // One clock edge of the specified behaviour, using key_in as sampled at that edge.
   task automatic model_edge();
      logic [N_KEYS-1:0] s_prev;
      logic              agree;
      if (cyc >= DEPTH) begin
         $display("FAIL model_depth: got %0d expected below %0d", cyc, DEPTH);
         $fatal(1, "model history exhausted");
      end
      s_prev  = m_stable;
      hist[cyc] = key_in;
      m_valid = 1'b0;
      m_err   = 1'b0;
      if (!m_hold) begin
         if (s_prev != '0) begin
            if ($countones(s_prev) == 1) begin
               m_onehot = s_prev;
               m_valid  = 1'b1;
            end else begin
               m_err = 1'b1;
            end
            m_hold = 1'b1;
         end
      end else if (s_prev == '0) begin
         m_hold = 1'b0;
      end
      // Accept once the last DB_CNT+1 synchronised samples all agree.
      agree = 1'b1;
      for (int j = 0; j <= DB_CNT; j++)
         if (samp(cyc - 2 - j) != samp(cyc - 2)) agree = 1'b0;
      if (agree) m_stable = samp(cyc - 2);
      cyc++;
   endtask

   task automatic tick();
      @(posedge clk);
      if (rst_n) model_edge();
      @(negedge clk);
      chk("key_onehot", 32'(key_onehot), 32'(m_onehot));
      chk("key_valid",  32'(key_valid),  32'(m_valid));
      chk("multi_err",  32'(multi_err),  32'(m_err));
      chk("key_busy",   32'(key_busy),   32'(m_hold));
      n_valid += int'(key_valid);
      n_err   += int'(multi_err);
   endtask

   task automatic run_vec(input int idx, input vec_t v);
      n_valid = 0;
      n_err   = 0;
      key_in  = v.pattern;
      repeat (v.hold) tick();
      key_in = '0;
      repeat (12) tick();
      chk("vec_valid_cnt", 32'(n_valid), 32'(v.exp_valid));
      chk("vec_err_cnt",   32'(n_err),   32'(v.exp_err));
      chk("vec_onehot",    32'(key_onehot), 32'(v.exp_onehot));
      chk("vec_busy_idle", 32'(key_busy), 32'd0);
      $display("vec %0d: pattern=%h hold=%0d valid=%0d err=%0d onehot=%h",
               idx, v.pattern, v.hold, n_valid, n_err, key_onehot);
   endtask

   initial begin
      vecs[0] = '{15'h4000, 10, 1, 0, 15'h4000};
      vecs[1] = '{15'h0003, 10, 0, 1, 15'h4000};
      vecs[2] = '{15'h0020,  3, 0, 0, 15'h4000};
      vecs[3] = '{15'h0020,  4, 0, 0, 15'h4000};
      vecs[4] = '{15'h0020,  5, 1, 0, 15'h0020};
      vecs[5] = '{15'h7FFF,  8, 0, 1, 15'h0020};
      vecs[6] = '{15'h0100, 12, 1, 0, 15'h0100};
      vecs[7] = '{15'h2000,  6, 1, 0, 15'h2000};

      // Reset held with every key pressed, then one cycle after release.
      key_in = 15'h7FFF;
      model_reset();
      repeat (3) tick();
      chk("rst_onehot", 32'(key_onehot), 32'd0);
      chk("rst_busy",   32'(key_busy),   32'd0);
      rst_n  = 1'b1;
      key_in = '0;
      tick();
      chk("rst_rel_valid", 32'(key_valid), 32'd0);
      chk("rst_rel_busy",  32'(key_busy),  32'd0);
      $display("reset: outputs onehot=%h valid=%b err=%b busy=%b", key_onehot, key_valid, multi_err, key_busy);
      repeat (6) tick();

      // Single press latency and release-to-idle latency.
      key_in = 15'h0001;
      for (int i = 0; i < 20; i++) begin
         tick();
         chk("lat_valid", 32'(key_valid), 32'(i == 7));
      end
      chk("lat_onehot", 32'(key_onehot), 32'h0001);
      chk("lat_busy",   32'(key_busy),   32'd1);
      key_in = '0;
      for (int i = 0; i < 12; i++) begin
         tick();
         chk("rel_busy", 32'(key_busy), 32'(i < 7));
      end
      chk("rel_onehot", 32'(key_onehot), 32'h0001);
      $display("latency: press/release sequence done, onehot=%h", key_onehot);

      for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);

      // Bouncing bit 14, then held.
      n_valid = 0;
      n_err   = 0;
      for (int c = 0; c < 12; c++) begin
         key_in = (((c / 2) % 2) == 0) ? 15'h4000 : 15'h0000;
         tick();
      end
      key_in = 15'h4000;
      repeat (20) tick();
      key_in = '0;
      repeat (12) tick();
      chk("bounce_valid", 32'(n_valid), 32'd1);
      chk("bounce_err",   32'(n_err),   32'd0);
      chk("bounce_onehot", 32'(key_onehot), 32'h4000);
      $display("bounce: valid=%0d err=%0d onehot=%h", n_valid, n_err, key_onehot);

      // Adding a key while held is ignored; a fresh press after release is taken.
      n_valid = 0;
      key_in  = 15'h0010;
      repeat (10) tick();
      chk("add_first_valid", 32'(n_valid), 32'd1);
      n_valid = 0;
      n_err   = 0;
      key_in  = 15'h0110;
      repeat (12) tick();
      chk("add_no_valid", 32'(n_valid), 32'd0);
      chk("add_no_err",   32'(n_err),   32'd0);
      chk("add_onehot",   32'(key_onehot), 32'h0010);
      key_in = '0;
      repeat (12) tick();
      n_valid = 0;
      key_in  = 15'h0100;
      repeat (10) tick();
      chk("add_new_valid",  32'(n_valid), 32'd1);
      chk("add_new_onehot", 32'(key_onehot), 32'h0100);
      key_in = '0;
      repeat (12) tick();
      $display("add-key: onehot=%h", key_onehot);

      // Asynchronous reset while a key is held; it is re-reported after release.
      key_in = 15'h0400;
      repeat (10) tick();
      chk("mid_busy_before", 32'(key_busy), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("async_onehot", 32'(key_onehot), 32'd0);
      chk("async_valid",  32'(key_valid),  32'd0);
      chk("async_err",    32'(multi_err),  32'd0);
      chk("async_busy",   32'(key_busy),   32'd0);
      model_reset();
      repeat (2) tick();
      rst_n = 1'b1;
      for (int i = 0; i < 16; i++) begin
         tick();
         chk("rerst_valid", 32'(key_valid), 32'(i == 7));
      end
      chk("rerst_onehot", 32'(key_onehot), 32'h0400);
      key_in = '0;
      repeat (12) tick();
      $display("mid-hold reset: onehot=%h", key_onehot);

      // Random key activity, including bounces shorter than the debounce window.
      for (int s = 0; s < 300; s++) begin
         int sel;
         int len;
         logic [N_KEYS-1:0] pat;
         sel = $urandom_range(0, 9);
         len = $urandom_range(1, 12);
         if (sel < 4)      pat = '0;
         else if (sel < 7) pat = N_KEYS'(1) << $urandom_range(0, N_KEYS - 1);
         else              pat = N_KEYS'($urandom);
         key_in = pat;
         repeat (len) tick();
         $display("rand %0d: key_in=%h cycles=%0d onehot=%h busy=%b", s, pat, len, key_onehot, key_busy);
      end
      key_in = '0;
      repeat (12) tick();
      chk("rand_end_busy", 32'(key_busy), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
